// File: rtl/dcache_port_arb_pkg.sv
// dcache_port_arb_pkg: shared state/request types and defaults for the dcache port arbiter
package dcache_port_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUED, MISS_WAIT} arb_state_t;
   typedef enum logic {REQ_LOAD, REQ_STORE} req_type_t;
   localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear wins over increment)
module sat_counter #(
   parameter int W   = 3,
   parameter int MAX = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_value
);
   logic [W-1:0] r_value;
   always_ff @(posedge clk)
      if (!rst_n || i_clr) r_value <= '0;
      else if (i_inc && r_value != W'(MAX)) r_value <= r_value + 1'b1;
   assign o_value = r_value;
endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: single-outstanding arbiter between MEM-stage loads and store-buffer commits
module dcache_port_arb
   import dcache_port_arb_pkg::*;
#(
   parameter int VA_WIDTH   = 8,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load_req,
   input  logic [VA_WIDTH-1:0] i_load_addr,
   output logic                o_load_grant,
   output logic                o_load_done,
   output logic                o_load_stall,
   input  logic                i_stb_valid,
   input  logic [VA_WIDTH-1:0] i_stb_addr,
   input  logic [VA_WIDTH-1:0] i_stb_data,
   input  logic                i_stb_full,
   output logic                o_stb_pop,
   input  logic                i_fence,
   output logic                o_fence_done,
   output logic                o_cache_req,
   output logic                o_cache_we,
   output logic [VA_WIDTH-1:0] o_cache_addr,
   output logic [VA_WIDTH-1:0] o_cache_wdata,
   input  logic                i_cache_hit,
   input  logic                i_cache_refill_done
);
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   arb_state_t          r_state, w_next;
   req_type_t           r_type;
   logic [VA_WIDTH-1:0] r_addr, r_wdata;
   logic [CW-1:0]       w_starve_cnt;
   logic                w_hit, w_arb, w_st_ok, w_ld_ok, w_force, w_iss_st, w_iss_ld, w_reissue;

   always_ff @(posedge clk)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;

   always_comb
      w_next = o_cache_req ? ISSUED :
               (r_state == ISSUED && !i_cache_hit) ? MISS_WAIT :
               (r_state == MISS_WAIT) ? MISS_WAIT : IDLE;

   // everything is gated by rst_n so a reset cycle never issues, pops or completes
   always_comb begin
      w_hit         = rst_n && r_state == ISSUED && i_cache_hit;
      o_stb_pop     = w_hit && r_type == REQ_STORE;
      o_load_done   = w_hit && r_type == REQ_LOAD;
      w_arb         = rst_n && (r_state == IDLE || w_hit);
      w_st_ok       = i_stb_valid && !o_stb_pop;
      w_ld_ok       = i_load_req && !o_load_done && !i_fence;
      w_force       = i_fence || i_stb_full || w_starve_cnt == CW'(STARVE_MAX);
      w_iss_st      = w_arb && w_st_ok && (w_force || !w_ld_ok);
      w_iss_ld      = w_arb && w_ld_ok && !w_iss_st;
      w_reissue     = rst_n && r_state == MISS_WAIT && i_cache_refill_done;
      o_load_grant  = w_iss_ld;
      o_cache_req   = w_iss_st || w_iss_ld || w_reissue;
      o_cache_we    = w_reissue ? (r_type == REQ_STORE) : w_iss_st;
      o_cache_addr  = w_reissue ? r_addr : w_iss_st ? i_stb_addr : w_iss_ld ? i_load_addr : '0;
      o_cache_wdata = w_reissue ? r_wdata : w_iss_st ? i_stb_data : '0;
      o_load_stall  = i_load_req && !o_load_done;
      o_fence_done  = rst_n && i_fence && r_state == IDLE && !i_stb_valid;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         r_type  <= REQ_LOAD;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_iss_st || w_iss_ld) begin
         r_type  <= w_iss_st ? REQ_STORE : REQ_LOAD;
         r_addr  <= o_cache_addr;
         r_wdata <= o_cache_wdata;
      end

   sat_counter #(.W(CW), .MAX(STARVE_MAX)) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_iss_ld && i_stb_valid),
      .i_clr   (w_iss_st || !i_stb_valid),
      .o_value (w_starve_cnt)
   );
endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: directed scenarios with an issue scoreboard for dcache_port_arb
module tb_dcache_port_arb;
   import dcache_port_arb_pkg::*;
   logic       clk = 1'b0;
   logic       rst_n, i_load_req, i_stb_valid, i_stb_full, i_fence, i_cache_hit, i_cache_refill_done;
   logic [7:0] i_load_addr, i_stb_addr, i_stb_data;
   logic       o_load_grant, o_load_done, o_load_stall, o_stb_pop, o_fence_done, o_cache_req, o_cache_we;
   logic [7:0] o_cache_addr, o_cache_wdata;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } iss_t;
   iss_t sb[$];
   int   n_err = 0;
   int   n_chk = 0;

   always #5 clk = ~clk;

   dcache_port_arb dut (
      .clk(clk), .rst_n(rst_n),
      .i_load_req(i_load_req), .i_load_addr(i_load_addr),
      .o_load_grant(o_load_grant), .o_load_done(o_load_done), .o_load_stall(o_load_stall),
      .i_stb_valid(i_stb_valid), .i_stb_addr(i_stb_addr), .i_stb_data(i_stb_data),
      .i_stb_full(i_stb_full), .o_stb_pop(o_stb_pop),
      .i_fence(i_fence), .o_fence_done(o_fence_done),
      .o_cache_req(o_cache_req), .o_cache_we(o_cache_we),
      .o_cache_addr(o_cache_addr), .o_cache_wdata(o_cache_wdata),
      .i_cache_hit(i_cache_hit), .i_cache_refill_done(i_cache_refill_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_iss(input logic we, input logic [7:0] a, input logic [7:0] d);
      iss_t e;
      e.we = we;
      e.addr = a;
      e.wdata = d;
      sb.push_back(e);
   endtask

   task automatic look();
      #2;
   endtask

   // every observed cache request must match the oldest expected issue
   task automatic step();
      iss_t e;
      if (o_cache_req) begin
         if (sb.size() == 0) chk("spurious_req", 32'(o_cache_req), 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_we", 32'(o_cache_we), 32'(e.we));
            chk("sb_addr", 32'(o_cache_addr), 32'(e.addr));
            chk("sb_wdata", 32'(o_cache_wdata), 32'(e.wdata));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0; i_load_req = 0; i_load_addr = 0; i_stb_valid = 1; i_stb_addr = 8'h05; i_stb_data = 8'h06;
      i_stb_full = 0; i_fence = 1; i_cache_hit = 0; i_cache_refill_done = 0;
      repeat (2) @(posedge clk);
      #1;
      look();
      chk("rst_req", 32'(o_cache_req), 0); chk("rst_grant", 32'(o_load_grant), 0);
      chk("rst_done", 32'(o_load_done), 0); chk("rst_pop", 32'(o_stb_pop), 0);
      chk("rst_fence_done", 32'(o_fence_done), 0); chk("rst_state", 32'(dut.r_state), 32'(IDLE));
      step();
      rst_n = 1; i_fence = 0; i_stb_valid = 0;
      look(); chk("idle_req", 32'(o_cache_req), 0); step();
      // store commit, pop, then next entry issues
      i_stb_valid = 1; i_stb_addr = 8'h10; i_stb_data = 8'hAA; expect_iss(1, 8'h10, 8'hAA);
      look(); chk("A_req", 32'(o_cache_req), 1); step();
      i_cache_hit = 1;
      look(); chk("A_pop", 32'(o_stb_pop), 1); chk("A_no_stale_issue", 32'(o_cache_req), 0); step();
      i_cache_hit = 0; expect_iss(1, 8'h10, 8'hAA);
      look(); chk("A_reissue", 32'(o_cache_req), 1); step();
      i_cache_hit = 1; i_stb_valid = 0;
      look(); chk("A_pop2", 32'(o_stb_pop), 1); step();
      // stb_full beats a pending load
      i_cache_hit = 0; i_stb_valid = 1; i_stb_addr = 8'h40; i_stb_data = 8'h55; i_stb_full = 1;
      i_load_req = 1; i_load_addr = 8'h20; expect_iss(1, 8'h40, 8'h55);
      look(); chk("B_grant", 32'(o_load_grant), 0); chk("B_we", 32'(o_cache_we), 1); step();
      i_stb_valid = 0; i_stb_full = 0; i_cache_hit = 1; expect_iss(0, 8'h20, 8'h00);
      look(); chk("B_pop", 32'(o_stb_pop), 1); chk("B_grant2", 32'(o_load_grant), 1);
      chk("B_stall", 32'(o_load_stall), 1); step();
      look(); chk("B_done", 32'(o_load_done), 1); chk("B_stall_done", 32'(o_load_stall), 0); step();
      // load held while stores pend: loads and stores alternate, counter cleared by each store
      i_cache_hit = 0; i_stb_valid = 1; i_stb_addr = 8'h50; i_stb_data = 8'h66; expect_iss(0, 8'h20, 8'h00);
      look(); chk("C_grant0", 32'(o_load_grant), 1); step();
      chk("C_cnt1", 32'(dut.w_starve_cnt), 1);
      i_cache_hit = 1;
      for (int i = 0; i < 4; i++) begin
         expect_iss(1, 8'h50, 8'h66);
         look(); chk("C_done", 32'(o_load_done), 1); chk("C_store_grant", 32'(o_load_grant), 0);
         chk("C_store_we", 32'(o_cache_we), 1); step();
         chk("C_cnt_clr", 32'(dut.w_starve_cnt), 0);
         if (i == 3) begin
            i_load_req = 0; i_stb_valid = 0;
         end else expect_iss(0, 8'h20, 8'h00);
         look(); chk("C_pop", 32'(o_stb_pop), 1); chk("C_load_grant", 32'(o_load_grant), 32'(i < 3)); step();
      end
      // load miss, refill, reissue, hit
      i_cache_hit = 0; i_load_req = 1; i_load_addr = 8'h30; expect_iss(0, 8'h30, 8'h00);
      look(); chk("D_grant", 32'(o_load_grant), 1); chk("D_stall0", 32'(o_load_stall), 1); step();
      look(); chk("D_miss_req", 32'(o_cache_req), 0); chk("D_stall1", 32'(o_load_stall), 1); step();
      i_cache_hit = 1;
      look(); chk("D_hit_ignored_req", 32'(o_cache_req), 0); chk("D_hit_ignored_done", 32'(o_load_done), 0);
      chk("D_stall2", 32'(o_load_stall), 1); step();
      i_cache_hit = 0;
      look(); chk("D_wait_req", 32'(o_cache_req), 0); chk("D_stall3", 32'(o_load_stall), 1); step();
      i_cache_refill_done = 1; expect_iss(0, 8'h30, 8'h00);
      look(); chk("D_reissue", 32'(o_cache_req), 1); chk("D_reissue_done", 32'(o_load_done), 0);
      chk("D_stall4", 32'(o_load_stall), 1); step();
      i_cache_refill_done = 0; i_cache_hit = 1;
      look(); chk("D_done", 32'(o_load_done), 1); chk("D_stall_end", 32'(o_load_stall), 0); step();
      // fence drains two stores before the load
      i_load_req = 0; i_cache_hit = 0;
      i_fence = 1; i_stb_valid = 1; i_stb_addr = 8'h60; i_stb_data = 8'h11; i_load_req = 1; i_load_addr = 8'h70;
      expect_iss(1, 8'h60, 8'h11);
      look(); chk("E_grant0", 32'(o_load_grant), 0); chk("E_fdone0", 32'(o_fence_done), 0); step();
      i_cache_hit = 1;
      look(); chk("E_pop1", 32'(o_stb_pop), 1); chk("E_req1", 32'(o_cache_req), 0); step();
      i_cache_hit = 0; i_stb_addr = 8'h61; i_stb_data = 8'h22; expect_iss(1, 8'h61, 8'h22);
      look(); chk("E_grant2", 32'(o_load_grant), 0); chk("E_req2", 32'(o_cache_req), 1); step();
      i_cache_hit = 1;
      look(); chk("E_pop2", 32'(o_stb_pop), 1); chk("E_req3", 32'(o_cache_req), 0);
      chk("E_fdone3", 32'(o_fence_done), 0); step();
      i_cache_hit = 0; i_stb_valid = 0;
      look(); chk("E_fdone", 32'(o_fence_done), 1); chk("E_grant4", 32'(o_load_grant), 0); step();
      i_fence = 0; expect_iss(0, 8'h70, 8'h00);
      look(); chk("E_load_after", 32'(o_load_grant), 1); chk("E_fdone_drop", 32'(o_fence_done), 0); step();
      i_cache_hit = 1;
      look(); chk("E_done", 32'(o_load_done), 1); step();
      // reset in MISS_WAIT, then refill pulse
      i_cache_hit = 0; i_load_req = 1; i_load_addr = 8'h80; expect_iss(0, 8'h80, 8'h00);
      look(); chk("F_grant", 32'(o_load_grant), 1); step();
      look(); step();
      rst_n = 0; i_cache_refill_done = 1;
      look(); chk("F_rst_req", 32'(o_cache_req), 0); chk("F_rst_done", 32'(o_load_done), 0); step();
      rst_n = 1; i_load_req = 0;
      look(); chk("F_state", 32'(dut.r_state), 32'(IDLE)); chk("F_no_reissue", 32'(o_cache_req), 0);
      chk("F_pop", 32'(o_stb_pop), 0); chk("F_done", 32'(o_load_done), 0); step();
      // reset in ISSUED with a hit drops the store without popping
      i_cache_refill_done = 0; i_stb_valid = 1; i_stb_addr = 8'h90; i_stb_data = 8'h33; expect_iss(1, 8'h90, 8'h33);
      look(); step();
      rst_n = 0; i_cache_hit = 1;
      look(); chk("F_issued_pop", 32'(o_stb_pop), 0); chk("F_issued_req", 32'(o_cache_req), 0); step();
      rst_n = 1; i_stb_valid = 0; i_cache_hit = 0;
      look(); chk("F_state2", 32'(dut.r_state), 32'(IDLE)); chk("F_req2", 32'(o_cache_req), 0); step();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
